// File: rtl/sr_latch_bank_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_bank_pkg : shared types and helpers for the sr_latch_bank SR cell bank.
// Revision    : 1.0
// ---------------------------------------------------------------------------
package sr_bank_pkg;

   // Resolution applied when a channel sees set and reset on the same edge.
   typedef enum logic [1:0] {
      SR_HOLD    = 2'd0,
      SR_SET_DOM = 2'd1,
      SR_RST_DOM = 2'd2,
      SR_TOGGLE  = 2'd3
   } sr_mode_e;

   // Widest request vector the popcount helper accepts.
   localparam int unsigned c_POP_W = 64;

   function automatic int unsigned popcount(input logic [c_POP_W-1:0] v);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < c_POP_W; i++) begin
         cnt = cnt + {31'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_bank_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_cell : one clocked SR storage channel with edge pulses and sticky flag.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sr_cell
   import sr_bank_pkg::*;
#(
   parameter sr_mode_e MODE      = SR_HOLD,
   parameter logic     RESET_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_s,
   input  logic i_r,
   input  logic i_clr,
   output logic o_q,
   output logic o_qb,
   output logic o_rise,
   output logic o_fall,
   output logic o_conflict
);

   logic r_q;
   logic r_qb;
   logic r_rise;
   logic r_fall;
   logic r_conflict;
   logic w_q_nxt;
   logic w_conflict;

   assign w_conflict = i_s & i_r;

   always_comb begin
      w_q_nxt = r_q;
      case ({i_s, i_r})
         2'b10:   w_q_nxt = 1'b1;
         2'b01:   w_q_nxt = 1'b0;
         2'b11: begin
            case (MODE)
               SR_SET_DOM: w_q_nxt = 1'b1;
               SR_RST_DOM: w_q_nxt = 1'b0;
               SR_TOGGLE:  w_q_nxt = ~r_q;
               default:    w_q_nxt = r_q;
            endcase
         end
         default: w_q_nxt = r_q;
      endcase
   end

   // qb is its own flop so it never glitches against q during reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q        <= RESET_BIT;
         r_qb       <= ~RESET_BIT;
         r_rise     <= 1'b0;
         r_fall     <= 1'b0;
         r_conflict <= 1'b0;
      end else if (i_en) begin
         r_q    <= w_q_nxt;
         r_qb   <= ~w_q_nxt;
         r_rise <= ~r_q & w_q_nxt;
         r_fall <= r_q & ~w_q_nxt;
         // A fresh conflict outranks a simultaneous clear.
         if (w_conflict) begin
            r_conflict <= 1'b1;
         end else if (i_clr) begin
            r_conflict <= 1'b0;
         end
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end
   end

   assign o_q        = r_q;
   assign o_qb       = r_qb;
   assign o_rise     = r_rise;
   assign o_fall     = r_fall;
   assign o_conflict = r_conflict;

endmodule
`default_nettype wire

// File: rtl/sr_latch_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_latch_bank : CH clocked SR channels with conflict flags and a saturating
//                 conflict-event counter. Revision: 1.0
// ---------------------------------------------------------------------------
module sr_latch_bank
   import sr_bank_pkg::*;
#(
   parameter int       CH        = 4,
   parameter int       CNT_W     = 8,
   parameter sr_mode_e MODE      = SR_HOLD,
   parameter logic [CH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CH-1:0]    s,
   input  logic [CH-1:0]    r,
   input  logic             clr_err,
   output logic [CH-1:0]    q,
   output logic [CH-1:0]    qb,
   output logic [CH-1:0]    rise,
   output logic [CH-1:0]    fall,
   output logic [CH-1:0]    conflict,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam int unsigned c_CNT_MAX = (32'd1 << CNT_W) - 32'd1;

   logic [CH-1:0]      w_conf_vec;
   logic [c_POP_W-1:0] w_pop_in;
   int unsigned        w_n_raw;
   logic [CNT_W-1:0]   w_n_sat;
   logic [CNT_W:0]     w_sum;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0]   r_cnt;

   generate
      for (genvar g = 0; g < CH; g++) begin : g_cell
         sr_cell #(
            .MODE      (MODE),
            .RESET_BIT (RESET_VAL[g])
         ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_en       (en),
            .i_s        (s[g]),
            .i_r        (r[g]),
            .i_clr      (clr_err),
            .o_q        (q[g]),
            .o_qb       (qb[g]),
            .o_rise     (rise[g]),
            .o_fall     (fall[g]),
            .o_conflict (conflict[g])
         );
      end
   endgenerate

   assign w_conf_vec = s & r & {CH{en}};

   always_comb begin
      w_pop_in = '0;
      w_pop_in[CH-1:0] = w_conf_vec;
   end

   assign w_n_raw = popcount(w_pop_in);

   // Clamp the per-cycle increment so the CNT_W+1 sum can never overflow.
   assign w_n_sat   = (w_n_raw > c_CNT_MAX) ? {CNT_W{1'b1}} : w_n_raw[CNT_W-1:0];
   assign w_sum     = {1'b0, r_cnt} + {1'b0, w_n_sat};
   assign w_cnt_nxt = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= clr_err ? w_n_sat : w_cnt_nxt;
      end
   end

   assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sr_latch_bank : one DUT per resolution mode, checked against a scoreboard.
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_sr_latch_bank;
   import sr_bank_pkg::*;

   localparam int CH    = 4;
   localparam int CNT_W = 4;
   localparam int NM    = 4;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b1;
   logic          en      = 1'b0;
   logic          clr_err = 1'b0;
   logic [CH-1:0] s       = '0;
   logic [CH-1:0] r       = '0;

   logic [CH-1:0]    q_o    [NM];
   logic [CH-1:0]    qb_o   [NM];
   logic [CH-1:0]    rise_o [NM];
   logic [CH-1:0]    fall_o [NM];
   logic [CH-1:0]    conf_o [NM];
   logic [CNT_W-1:0] cnt_o  [NM];

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < NM; g++) begin : g_dut
         sr_latch_bank #(
            .CH        (CH),
            .CNT_W     (CNT_W),
            .MODE      (sr_mode_e'(g)),
            .RESET_VAL (4'b0000)
         ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (en),
            .s            (s),
            .r            (r),
            .clr_err      (clr_err),
            .q            (q_o[g]),
            .qb           (qb_o[g]),
            .rise         (rise_o[g]),
            .fall         (fall_o[g]),
            .conflict     (conf_o[g]),
            .conflict_cnt (cnt_o[g])
         );
      end
   endgenerate

   typedef struct {
      logic [23:0] v [NM];
   } exp_t;

   exp_t        sb_q [$];
   exp_t        e;
   int          vectors     = 0;
   int          miscompares = 0;

   logic [CH-1:0] m_q    [NM];
   logic [CH-1:0] m_conf [NM];
   int            m_cnt  [NM];

   function automatic logic [23:0] obs(input int m);
      return {q_o[m], qb_o[m], rise_o[m], fall_o[m], conf_o[m], cnt_o[m]};
   endfunction

   task automatic model_reset();
      for (int m = 0; m < NM; m++) begin
         m_q[m]    = '0;
         m_conf[m] = '0;
         m_cnt[m]  = 0;
      end
   endtask

   // Drive one cycle of stimulus, push the model's prediction, then cross the edge.
   task automatic step(input logic t_en, input logic [CH-1:0] t_s,
                       input logic [CH-1:0] t_r, input logic t_clr);
      exp_t          x;
      logic [CH-1:0] nq;
      logic [CH-1:0] both;
      int            n;
      @(negedge clk);
      en = t_en; s = t_s; r = t_r; clr_err = t_clr;
      both = t_en ? (t_s & t_r) : '0;
      n    = $countones(both);
      for (int m = 0; m < NM; m++) begin
         nq = m_q[m];
         if (t_en) begin
            for (int i = 0; i < CH; i++) begin
               if (t_s[i] && !t_r[i])      nq[i] = 1'b1;
               else if (!t_s[i] && t_r[i]) nq[i] = 1'b0;
               else if (t_s[i] && t_r[i]) begin
                  if (m == 1)      nq[i] = 1'b1;
                  else if (m == 2) nq[i] = 1'b0;
                  else if (m == 3) nq[i] = ~m_q[m][i];
               end
            end
            m_conf[m] = t_clr ? both : (m_conf[m] | both);
            m_cnt[m]  = t_clr ? n : ((m_cnt[m] + n > 15) ? 15 : m_cnt[m] + n);
         end
         x.v[m] = {nq, ~nq,
                   t_en ? (~m_q[m] & nq) : 4'b0000,
                   t_en ? (m_q[m] & ~nq) : 4'b0000,
                   m_conf[m], 4'(m_cnt[m])};
         m_q[m] = nq;
      end
      sb_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      for (int m = 0; m < NM; m++) begin
         vectors++;
         if (obs(m) !== {4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0}) begin
            miscompares++;
            $display("FAIL reset mode%0d got=%h exp=%h", m, obs(m), 24'h0F0000);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_set_reset();
      logic [CH-1:0] ts [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
      logic [CH-1:0] tr [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
      for (int c = 0; c < 4; c++) begin
         step(1'b1, ts[c], tr[c], 1'b0);
         if (c == 0) begin
            vectors++;
            if (q_o[1] !== 4'b0001 || qb_o[1] !== 4'b1110 || rise_o[1] !== 4'b0001) begin
               miscompares++;
               $display("FAIL set_first q=%b qb=%b rise=%b exp 0001/1110/0001", q_o[1], qb_o[1], rise_o[1]);
            end
         end
         e = sb_q.pop_front();
         for (int m = 0; m < NM; m++) begin
            vectors++;
            if (obs(m) !== e.v[m]) begin
               miscompares++;
               $display("FAIL set_reset cyc%0d mode%0d got=%h exp=%h", c, m, obs(m), e.v[m]);
            end
         end
      end
   endtask

   task automatic test_hold_conflict();
      for (int c = 0; c < 5; c++) begin
         if (c == 0)      step(1'b1, 4'b0001, 4'b0000, 1'b0);
         else if (c < 4)  step(1'b1, 4'b0001, 4'b0001, 1'b0);
         else             step(1'b1, 4'b0000, 4'b0000, 1'b1);
         if (c == 3) begin
            vectors++;
            if (q_o[0] !== 4'b0001 || conf_o[0] !== 4'b0001 || cnt_o[0] !== 4'd3) begin
               miscompares++;
               $display("FAIL hold_cnt q=%b conf=%b cnt=%0d exp 0001/0001/3", q_o[0], conf_o[0], cnt_o[0]);
            end
         end
         e = sb_q.pop_front();
         for (int m = 0; m < NM; m++) begin
            vectors++;
            if (obs(m) !== e.v[m]) begin
               miscompares++;
               $display("FAIL hold_conflict cyc%0d mode%0d got=%h exp=%h", c, m, obs(m), e.v[m]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      int sat_tbl [5] = '{4, 8, 12, 15, 15};
      for (int c = 0; c < 5; c++) begin
         step(1'b1, 4'b1111, 4'b1111, 1'b0);
         vectors++;
         if (cnt_o[0] !== 4'(sat_tbl[c])) begin
            miscompares++;
            $display("FAIL saturation cyc%0d cnt=%0d exp=%0d", c, cnt_o[0], sat_tbl[c]);
         end
         e = sb_q.pop_front();
         for (int m = 0; m < NM; m++) begin
            vectors++;
            if (obs(m) !== e.v[m]) begin
               miscompares++;
               $display("FAIL saturation cyc%0d mode%0d got=%h exp=%h", c, m, obs(m), e.v[m]);
            end
         end
      end
   endtask

   task automatic test_toggle();
      logic [3:0] tq = 4'b1010;
      for (int c = 0; c < 5; c++) begin
         if (c == 0) step(1'b1, 4'b0000, 4'b1111, 1'b1);
         else        step(1'b1, 4'b0010, 4'b0010, 1'b0);
         if (c > 0) begin
            vectors++;
            if (q_o[3][1] !== tq[4-c] || rise_o[3][1] !== tq[4-c] || fall_o[3][1] !== ~tq[4-c]) begin
               miscompares++;
               $display("FAIL toggle cyc%0d q1=%b rise1=%b fall1=%b exp q1=%b", c, q_o[3][1], rise_o[3][1], fall_o[3][1], tq[4-c]);
            end
         end
         e = sb_q.pop_front();
         for (int m = 0; m < NM; m++) begin
            vectors++;
            if (obs(m) !== e.v[m]) begin
               miscompares++;
               $display("FAIL toggle cyc%0d mode%0d got=%h exp=%h", c, m, obs(m), e.v[m]);
            end
         end
      end
   endtask

   task automatic test_clr_collision();
      logic [CH-1:0] ts [5] = '{4'b0000, 4'b1111, 4'b1111, 4'b0001, 4'b0011};
      logic          tc [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 5; c++) begin
         step(1'b1, ts[c], ts[c], tc[c]);
         if (c == 3 || c == 4) begin
            vectors++;
            if (cnt_o[2] !== ((c == 3) ? 4'd9 : 4'd2) || (c == 4 && conf_o[2] !== 4'b0011)) begin
               miscompares++;
               $display("FAIL clr_collision cyc%0d cnt=%0d conf=%b", c, cnt_o[2], conf_o[2]);
            end
         end
         e = sb_q.pop_front();
         for (int m = 0; m < NM; m++) begin
            vectors++;
            if (obs(m) !== e.v[m]) begin
               miscompares++;
               $display("FAIL clr_collision cyc%0d mode%0d got=%h exp=%h", c, m, obs(m), e.v[m]);
            end
         end
      end
   endtask

   task automatic test_freeze_async_reset();
      for (int c = 0; c < 4; c++) begin
         if (c == 0) step(1'b1, 4'b1111, 4'b0000, 1'b0);
         else        step(1'b0, 4'b1111, 4'b1111, 1'b0);
         e = sb_q.pop_front();
         for (int m = 0; m < NM; m++) begin
            vectors++;
            if (obs(m) !== e.v[m]) begin
               miscompares++;
               $display("FAIL freeze cyc%0d mode%0d got=%h exp=%h", c, m, obs(m), e.v[m]);
            end
         end
      end
      #2 rst_n = 1'b0;
      #1;
      for (int m = 0; m < NM; m++) begin
         vectors++;
         if (obs(m) !== {4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0}) begin
            miscompares++;
            $display("FAIL async_reset mode%0d got=%h exp=%h", m, obs(m), 24'h0F0000);
         end
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_set_reset();
      test_hold_conflict();
      test_saturation();
      test_toggle();
      test_clr_collision();
      test_freeze_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
